// File: rtl/sum_display_driver_pkg.sv
// Shared types and constants for the adder-result display driver:
// FSM encodings, active-low 7-segment patterns and the default scan divider.
package sum_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int REFRESH_DIV_DEF = 100000;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;

endpackage

// File: rtl/sum_display_driver_if.sv
// Adder-result capture and board display signals, seen from the adder side
// (master) and from the display driver (slave).
interface sum_display_driver_if #(
  parameter int SUM_W = 4
);
  logic             sum_valid;
  logic [SUM_W-1:0] s;
  logic             cout;
  logic [6:0]       seg;
  logic [3:0]       an;
  logic             busy;
  logic             done;

  modport master (
    output sum_valid, s, cout,
    input  seg, an, busy, done
  );

  modport slave (
    input  sum_valid, s, cout,
    output seg, an, busy, done
  );
endinterface

// File: rtl/sum_display_driver_bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder; codes 10..15
// have no digit and show as blank.
module bcd_to_seg7
  import sum_display_driver_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_display_driver.sv
// Captures {cout,s} from the ripple adder, converts it to two BCD digits with
// a bit-serial double-dabble and scans them onto a multiplexed 7-segment display.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for sum_valid; display holds the last result
// ST_SHIFT | one add-3/shift step per cycle, SUM_W+1 steps
// ST_DONE  | latch tens/ones into the display, pulse done
module sum_display_driver
  import sum_display_driver_pkg::*;
#(
  parameter int SUM_W       = 4,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  sum_display_driver_if.slave bus
);

  localparam int BW    = SUM_W + 1;
  localparam int SRW   = BW + 8;
  localparam int CW    = $clog2(BW + 1);
  localparam int RCW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t           r_state;
  logic [SRW-1:0]   r_shreg;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_busy;
  logic             r_done;
  logic [RCW-1:0]   r_refresh;
  logic             r_sel;

  logic [SRW-1:0]   w_adj;
  logic [SRW-1:0]   w_shifted;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg_dec;
  logic [6:0]       w_seg;
  logic [3:0]       w_an;

  // Add-3 correction happens before the shift so no nibble ever passes 9
  always_comb begin
    w_adj = r_shreg;
    if (r_shreg[BW+7:BW+4] >= 4'd5) w_adj[BW+7:BW+4] = r_shreg[BW+7:BW+4] + 4'd3;
    if (r_shreg[BW+3:BW]   >= 4'd5) w_adj[BW+3:BW]   = r_shreg[BW+3:BW]   + 4'd3;
    w_shifted = {w_adj[SRW-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.sum_valid) begin
            r_shreg <= {8'd0, bus.cout, bus.s};
            r_cnt   <= CW'(BW);
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shreg <= w_shifted;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_tens  <= r_shreg[BW+7:BW+4];
          r_ones  <= r_shreg[BW+3:BW];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Digit scan is free-running and independent of the conversion FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_sel     <= 1'b0;
    end else if (r_refresh == RCW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_sel     <= ~r_sel;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  assign w_digit = r_sel ? r_tens : r_ones;

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  // Leading zero in the tens slot is blanked; the anode still selects it
  assign w_seg = (r_sel && (r_tens == 4'd0)) ? SEG_BLANK : w_seg_dec;
  assign w_an  = r_sel ? AN_TENS : AN_ONES;

  assign bus.seg  = w_seg;
  assign bus.an   = w_an;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_sum_display_driver.sv
// Self-checking bench for sum_display_driver: directed and random sums checked
// against an arithmetic tens/ones model, plus scan timing and reset behaviour.
module tb_sum_display_driver;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   shown_v;

  logic [6:0] seg_tab [10];

  sum_display_driver_if #(.SUM_W(4)) bus ();

  sum_display_driver #(.SUM_W(4), .REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int v, input logic [3:0] an);
    if (an == 4'b1101) return (v / 10 == 0) ? 7'b1111111 : seg_tab[v / 10];
    return seg_tab[v % 10];
  endfunction

  task automatic sample_slot(input logic [3:0] want_an, output logic [6:0] seg_o, output bit ok);
    ok = 1'b0;
    seg_o = 7'bx;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.an === want_an) begin
        seg_o = bus.seg;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bus.sum_valid = 1'b0; bus.s = 4'd0; bus.cout = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: an=%b seg=%b busy=%b done=%b, want an=1110 seg=1000000 busy=0 done=0",
               bus.an, bus.seg, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    shown_v = 0;
    @(negedge clk);
    n_checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_release: an=%b seg=%b, want 1110/1000000", bus.an, bus.seg);
    end
  endtask

  task automatic test_convert(input int v, input string name);
    int busy_cyc, done_cnt, done_k;
    logic [6:0] sg;
    bit ok;
    busy_cyc = 0; done_cnt = 0; done_k = -1;
    @(negedge clk);
    bus.sum_valid = 1'b1;
    {bus.cout, bus.s} = 5'(v);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) bus.sum_valid = 1'b0;
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) begin done_cnt++; done_k = k; end
      if (k == 5) begin
        n_checks++;
        if (bus.seg !== exp_seg(shown_v, bus.an)) begin
          n_fail++;
          $display("FAIL %s_hold_old: an=%b seg=%b, want seg=%b", name, bus.an, bus.seg, exp_seg(shown_v, bus.an));
        end
      end
      if (k == 6) begin
        n_checks++;
        if (bus.seg !== exp_seg(v, bus.an)) begin
          n_fail++;
          $display("FAIL %s_new_at_done: an=%b seg=%b, want seg=%b", name, bus.an, bus.seg, exp_seg(v, bus.an));
        end
      end
    end
    n_checks++;
    if (busy_cyc != 6 || done_cnt != 1 || done_k != 6) begin
      n_fail++;
      $display("FAIL %s_timing: busy_cycles=%0d done_pulses=%0d done_at=%0d, want 6/1/6", name, busy_cyc, done_cnt, done_k);
    end
    if (done_cnt > 0) shown_v = v;
    sample_slot(4'b1110, sg, ok);
    n_checks++;
    if (!ok || sg !== seg_tab[v % 10]) begin
      n_fail++;
      $display("FAIL %s_ones: found=%0b seg=%b, want seg=%b", name, ok, sg, seg_tab[v % 10]);
    end
    sample_slot(4'b1101, sg, ok);
    n_checks++;
    if (!ok || sg !== ((v / 10 == 0) ? 7'b1111111 : seg_tab[v / 10])) begin
      n_fail++;
      $display("FAIL %s_tens: found=%0b seg=%b, want seg=%b", name, ok, sg,
               (v / 10 == 0) ? 7'b1111111 : seg_tab[v / 10]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) test_convert(int'($urandom_range(0, 31)), "random");
  endtask

  task automatic test_drop_while_busy();
    int done_cnt, done_k;
    logic [6:0] sg;
    bit ok;
    done_cnt = 0; done_k = -1;
    @(negedge clk);
    bus.sum_valid = 1'b1; bus.cout = 1'b0; bus.s = 4'd5;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin done_cnt++; done_k = k; end
      bus.sum_valid = (k == 1);
      if (k == 1) bus.s = 4'b1100;
    end
    n_checks++;
    if (done_cnt != 1 || done_k != 6) begin
      n_fail++;
      $display("FAIL drop_done: pulses=%0d at=%0d, want 1 at 6", done_cnt, done_k);
    end
    shown_v = 5;
    sample_slot(4'b1110, sg, ok);
    n_checks++;
    if (!ok || sg !== 7'b0010010) begin
      n_fail++;
      $display("FAIL drop_ones: found=%0b seg=%b, want 0010010", ok, sg);
    end
    sample_slot(4'b1101, sg, ok);
    n_checks++;
    if (!ok || sg !== 7'b1111111) begin
      n_fail++;
      $display("FAIL drop_tens: found=%0b seg=%b, want 1111111", ok, sg);
    end
  endtask

  task automatic test_scan();
    int bad;
    logic [3:0] want;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    shown_v = 0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      want = (((k / 4) % 2) == 1) ? 4'b1101 : 4'b1110;
      if (bus.an !== want) begin
        bad++;
        if (bad == 1) $display("FAIL scan_an: edge=%0d an=%b, want %b", k, bus.an, want);
      end
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) n_fail++;
  endtask

  task automatic test_reset_mid_conversion();
    int done_cnt;
    logic [6:0] sg;
    bit ok;
    @(negedge clk);
    bus.sum_valid = 1'b1; bus.cout = 1'b1; bus.s = 4'b0111;
    @(negedge clk);
    bus.sum_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.an !== 4'b1110 || bus.seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL midreset_async: busy=%b an=%b seg=%b, want 0/1110/1000000", bus.busy, bus.an, bus.seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    shown_v = 0;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: busy_or_done_cycles=%0d, want 0", done_cnt);
    end
    sample_slot(4'b1110, sg, ok);
    n_checks++;
    if (!ok || sg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL midreset_ones: found=%0b seg=%b, want 1000000", ok, sg);
    end
    sample_slot(4'b1101, sg, ok);
    n_checks++;
    if (!ok || sg !== 7'b1111111) begin
      n_fail++;
      $display("FAIL midreset_tens: found=%0b seg=%b, want 1111111", ok, sg);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    shown_v  = 0;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    test_reset();
    test_convert(9, "nine");
    test_convert(16, "sixteen");
    test_convert(31, "max31");
    test_convert(0, "zero");
    test_convert(10, "ten");
    test_random();
    test_drop_while_busy();
    test_scan();
    test_reset_mid_conversion();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
